multi_issue_fetch: RTL
======================

Name: multi_issue_fetch

Overview:
Parametrised successor to the dual-issue instruction fetch unit. It fetches ISSUE_WIDTH 32-bit big-endian instructions per cycle from an internal byte-addressed instruction memory and emits them as one registered bundle with per-lane valid bits. It adds a valid/ready backpressure handshake, a PC redirect port for branches, an explicit start/done sequence, and a byte write port for loading the memory. It sits in front of decode; decode consumes one bundle per accepted handshake.

Parameters:
ISSUE_WIDTH, 2, instructions per bundle (1..8)
IMEM_BYTES, 1024, instruction memory size in bytes (multiple of 4)
PC_W, 32, PC and address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk)
start  in  1  begin fetching from PC 0 (sampled in IDLE only)
total_instructions  in  32  program length in instructions, latched when start is accepted
ready  in  1  decode can accept a bundle this cycle
redirect_valid  in  1  branch redirect request
redirect_pc  in  PC_W  redirect target byte address
imem_we  in  1  memory byte write enable
imem_waddr  in  PC_W  memory byte write address
imem_wdata  in  8  memory byte write data
instr_bundle  out  32*ISSUE_WIDTH  lane k = bits [32k+31:32k]
lane_valid  out  ISSUE_WIDTH  per-lane valid
pc_out  out  PC_W  byte address of lane 0
valid  out  1  bundle present
done  out  1  program exhausted

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, pc=0, valid=0, lane_valid=0, instr_bundle=0, pc_out=0, done=0. Memory contents are not reset. Reset overrides all other inputs.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch total_instructions, pc=0, go to RUN. Outputs stay 0. The first bundle is registered on the edge after entering RUN, so valid rises 2 cycles after start is sampled.
- end_addr = min(total_instructions*4, IMEM_BYTES). Compute it at width PC_W+2 so that it cannot overflow.
- RUN, output slot free (valid==0 or ready==1):
  - If pc < end_addr: register the bundle. Lane k = {mem[pc+4k], mem[pc+4k+1], mem[pc+4k+2], mem[pc+4k+3]}, with lane_valid[k] = (pc+4k < end_addr).
  - Invalid lanes output 32'b0 (NOP).
  - Set pc_out=pc, valid=1, pc += 4*ISSUE_WIDTH.
  - Else: valid=0, lane_valid=0, instr_bundle=0, done=1, go to DONE.
- RUN, stall (valid==1 and ready==0): instr_bundle, lane_valid, pc_out, valid and pc all hold.
- DONE: valid=0, done=1, bundle outputs 0. Only redirect or reset leaves DONE.
- Redirect (RUN or DONE; ignored in IDLE):
  - pc = redirect_pc with bits [1:0] cleared, valid=0, lane_valid=0, done=0, go to RUN.
  - Any pending bundle is discarded.
  - Redirect has priority over ready and over normal advance.
  - The next bundle appears on the following edge.
- Memory: one byte write per cycle when imem_we=1 and imem_waddr < IMEM_BYTES; out-of-range writes are ignored. A write lands at the edge. A fetch registered on that same edge sees the old byte.
- Reads with address >= IMEM_BYTES return 0. This cannot produce a valid lane because of the end_addr clamp.
- start in RUN or DONE is ignored.

Test Plan:
1. ISSUE_WIDTH=2, load 5 instructions 0x11111111..0x55555555, total=5, ready=1, pulse start -> bundles:
   - pc_out=0x0, lane_valid=2'b11
   - pc_out=0x8, lane_valid=2'b11
   - pc_out=0x10, lane_valid=2'b01 with lane1=0
   - then valid=0 and done=1 on the next cycle.
2. Same program, hold ready=0 for 3 cycles once the first bundle is valid -> instr_bundle=={0x22222222,0x11111111} and pc_out=0 stable for all 3 cycles; release ready -> next bundle has pc_out=0x8, with none skipped or duplicated.
3. Mid-run redirect_valid=1 with redirect_pc=0x0E -> valid=0 next cycle, then pc_out=0x0C with lane0 = instruction 3. In DONE, redirect to 0x0 -> done=0 and fetch restarts from 0x0.
4. total=0, pulse start -> done=1 two cycles later, valid never asserted. total=300 with IMEM_BYTES=1024 -> fetch stops after pc_out=0x3F8 (clamp to 256 instructions).
5. Drive reset=0 during RUN with valid=1 -> after the next edge all outputs are 0 and state is IDLE. Pulse start again -> the same bundles are fetched as in scenario 1, proving memory is preserved.
6. Write byte 0xAB to address 0 on the same edge a bundle at pc 0 is registered -> lane0 carries the old byte. After a redirect to 0, lane0 = 0xAB111111.

Source files
------------

// File: rtl/multi_issue_fetch.sv
// Multi-issue instruction fetch: ISSUE_WIDTH big-endian 32-bit instructions per
// registered bundle, with valid/ready backpressure, branch redirect, start/done
// sequencing and a byte write port for loading the internal instruction memory.
module multi_issue_fetch #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int unsigned PC_W        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               total_instructions,
    input  logic                      ready,
    input  logic                      redirect_valid,
    input  logic [PC_W-1:0]           redirect_pc,
    input  logic                      imem_we,
    input  logic [PC_W-1:0]           imem_waddr,
    input  logic [7:0]                imem_wdata,
    output logic [32*ISSUE_WIDTH-1:0] instr_bundle,
    output logic [ISSUE_WIDTH-1:0]    lane_valid,
    output logic [PC_W-1:0]           pc_out,
    output logic                      valid,
    output logic                      done
);

    localparam int unsigned EW   = PC_W + 2;
    localparam int unsigned MW   = (EW > 34) ? EW : 34;
    localparam int unsigned AW   = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam int unsigned BW   = 32 * ISSUE_WIDTH;
    localparam int unsigned STEP = 4 * ISSUE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    logic [7:0] mem [IMEM_BYTES];

    state_t                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [EW-1:0]          end_q, end_d;
    logic [BW-1:0]          bundle_q, bundle_d;
    logic [ISSUE_WIDTH-1:0] lv_q, lv_d;
    logic [PC_W-1:0]        pc_out_q, pc_out_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;

    logic [BW-1:0]          fetch_bundle;
    logic [ISSUE_WIDTH-1:0] fetch_lv;
    logic [MW-1:0]          prod_bytes;
    logic [EW-1:0]          end_calc;

    assign instr_bundle = bundle_q;
    assign lane_valid   = lv_q;
    assign pc_out       = pc_out_q;
    assign valid        = valid_q;
    assign done         = done_q;

    // Byte write port; out-of-range addresses are dropped. Contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we && ({2'b00, imem_waddr} < EW'(IMEM_BYTES))) begin
            mem[AW'(imem_waddr)] <= imem_wdata;
        end
    end

    // Program end address, clamped to the memory size at a width that cannot overflow.
    always_comb begin
        prod_bytes = MW'(total_instructions) << 2;
        end_calc   = (prod_bytes < MW'(IMEM_BYTES)) ? EW'(prod_bytes) : EW'(IMEM_BYTES);
    end

    // Assemble the candidate bundle at the current pc; lanes past the end read as NOP.
    always_comb begin
        logic [EW-1:0] lane_addr;
        logic [EW-1:0] byte_addr;
        logic [31:0]   word;
        fetch_bundle = '0;
        fetch_lv     = '0;
        lane_addr    = '0;
        byte_addr    = '0;
        word         = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane_addr   = EW'(pc_q) + EW'(4 * k);
            fetch_lv[k] = (lane_addr < end_q);
            word        = '0;
            for (int b = 0; b < 4; b++) begin
                byte_addr = lane_addr + EW'(b);
                word      = {word[23:0],
                             (byte_addr < EW'(IMEM_BYTES)) ? mem[AW'(byte_addr)] : 8'h00};
            end
            fetch_bundle[32*k +: 32] = fetch_lv[k] ? word : 32'h0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        end_d    = end_q;
        bundle_d = bundle_q;
        lv_d     = lv_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    end_d   = end_calc;
                    pc_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_DONE: begin
                if (redirect_valid) begin
                    pc_d     = redirect_pc & ~PC_W'(3);
                    valid_d  = 1'b0;
                    lv_d     = '0;
                    bundle_d = '0;
                    done_d   = 1'b0;
                    state_d  = ST_RUN;
                end else if ((state_q == ST_RUN) && (!valid_q || ready)) begin
                    if ({2'b00, pc_q} < end_q) begin
                        bundle_d = fetch_bundle;
                        lv_d     = fetch_lv;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + PC_W'(STEP);
                    end else begin
                        bundle_d = '0;
                        lv_d     = '0;
                        valid_d  = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            end_q    <= '0;
            bundle_q <= '0;
            lv_q     <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            end_q    <= end_d;
            bundle_q <= bundle_d;
            lv_q     <= lv_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

endmodule
